as_op_sequencer: RTL and testbench

//  Upstream operand sequencer for the AS_4bit adder/subtractor. Accepts ops on a

---
 rtl/as_op_sequencer.sv | 168 ++++++++++++++++
 tb/tb_as_op_sequencer.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/as_op_sequencer.sv
// as_op_sequencer
//   Operand sequencer for the AS_4bit combinational adder/subtractor.
//   - Accepts one op on the in_* valid/ready port.
//   - Drives as_A/as_B/as_M and holds them for SETTLE cycles.
//   - Captures as_s/as_cout and adds zero and overflow flags.
//   - Returns the result on the out_* valid/ready port.
//   - Keeps an accumulator, so ACC ops can chain on the last result.
//
// Parameters
//   WIDTH   operand/result width (must match the adder)
//   SETTLE  number of DRIVE cycles before capture, 1..15
//
// Ports
//   clk, rst             clock (rising edge) and asynchronous active-high reset
//   in_valid/in_ready    op handshake
//   in_op                0=ADD a+b, 1=SUB a-b, 2=ACC_ADD acc+b, 3=ACC_SUB acc-b
//   in_a, in_b           operands (in_a is ignored for ACC ops)
//   as_A, as_B, as_M     to the adder
//   as_s, as_cout        from the adder
//   out_valid/out_ready  result handshake
//   out_res              result
//   out_carry            raw adder carry (for SUB, 1 = no borrow)
//   out_zero, out_ovf    zero and two's-complement overflow flags
//   acc                  accumulator value
//
// Build option
//   AS_SEQ_SAT_EN        when defined, unsigned saturation is applied at capture
//                        (affects out_res, out_zero and acc only)
module as_op_sequencer #(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic [WIDTH-1:0] as_A,
    output logic [WIDTH-1:0] as_B,
    output logic             as_M,
    input  logic [WIDTH-1:0] as_s,
    input  logic             as_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_res,
    output logic             out_carry,
    output logic             out_zero,
    output logic             out_ovf,
    output logic [WIDTH-1:0] acc
);

    typedef enum logic [1:0] {StIdle, StDrive, StHold} state_e;

    state_e             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic               m_q, m_d;
    logic [WIDTH-1:0]   acc_q, acc_d, res_q, res_d;
    logic               valid_q, valid_d, carry_q, carry_d;
    logic               zero_q, zero_d, ovf_q, ovf_d;
    logic [WIDTH-1:0]   beff;
    logic [WIDTH-1:0]   res_cap;

    assign in_ready = (state_q == StIdle) & ~rst;

    // Effective B as the adder sees it (inverted for subtract).
    assign beff = b_q ^ {WIDTH{m_q}};

`ifdef AS_SEQ_SAT_EN
    // Unsigned saturation: ADD overflow clamps high, SUB borrow clamps low.
    always_comb begin
        res_cap = as_s;
        if (!m_q && as_cout) begin
            res_cap = '1;
        end else if (m_q && !as_cout) begin
            res_cap = '0;
        end
    end
`else
    assign res_cap = as_s;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        m_d     = m_q;
        acc_d   = acc_q;
        res_d   = res_q;
        valid_d = valid_q;
        carry_d = carry_q;
        zero_d  = zero_q;
        ovf_d   = ovf_q;
        case (state_q)
            StIdle: begin
                if (in_valid && in_ready) begin
                    a_d     = in_op[1] ? acc_q : in_a;
                    b_d     = in_b;
                    m_d     = in_op[0];
                    cnt_d   = 4'(SETTLE - 1);
                    state_d = StDrive;
                end
            end
            StDrive: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    res_d   = res_cap;
                    carry_d = as_cout;
                    zero_d  = (res_cap == '0);
                    ovf_d   = (a_q[WIDTH-1] == beff[WIDTH-1]) & (as_s[WIDTH-1] != a_q[WIDTH-1]);
                    acc_d   = res_cap;
                    valid_d = 1'b1;
                    state_d = StHold;
                end
            end
            StHold: begin
                if (out_ready) begin
                    valid_d = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            a_q     <= '0;
            b_q     <= '0;
            m_q     <= 1'b0;
            acc_q   <= '0;
            res_q   <= '0;
            valid_q <= 1'b0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            m_q     <= m_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
            valid_q <= valid_d;
            carry_q <= carry_d;
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
        end
    end

    assign as_A      = a_q;
    assign as_B      = b_q;
    assign as_M      = m_q;
    assign acc       = acc_q;
    assign out_res   = res_q;
    assign out_valid = valid_q;
    assign out_carry = carry_q;
    assign out_zero  = zero_q;
    assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_as_op_sequencer.sv
module tb_as_op_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // SETTLE=1 instance
    logic       in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
    logic [1:0] in_op = 2'd0;
    logic [3:0] in_a = '0, in_b = '0, as_a, as_b, as_s, out_res, acc;
    logic       as_m, as_cout, out_carry, out_zero, out_ovf;

    // SETTLE=3 instance
    logic       in_valid3 = 1'b0, in_ready3, out_valid3, out_ready3 = 1'b0;
    logic [1:0] in_op3 = 2'd0;
    logic [3:0] in_a3 = '0, in_b3 = '0, as_a3, as_b3, as_s3, out_res3, acc3;
    logic       as_m3, as_cout3, out_carry3, out_zero3, out_ovf3;

    // Behavioural stand-in for the AS_4bit adder/subtractor.
    assign {as_cout, as_s}   = {1'b0, as_a} + {1'b0, as_b ^ {4{as_m}}} + {4'b0, as_m};
    assign {as_cout3, as_s3} = {1'b0, as_a3} + {1'b0, as_b3 ^ {4{as_m3}}} + {4'b0, as_m3};

    as_op_sequencer #(.WIDTH(4), .SETTLE(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_a(in_a), .in_b(in_b), .as_A(as_a), .as_B(as_b), .as_M(as_m), .as_s(as_s),
        .as_cout(as_cout), .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res),
        .out_carry(out_carry), .out_zero(out_zero), .out_ovf(out_ovf), .acc(acc)
    );

    as_op_sequencer #(.WIDTH(4), .SETTLE(3)) dut3 (
        .clk(clk), .rst(rst), .in_valid(in_valid3), .in_ready(in_ready3), .in_op(in_op3),
        .in_a(in_a3), .in_b(in_b3), .as_A(as_a3), .as_B(as_b3), .as_M(as_m3), .as_s(as_s3),
        .as_cout(as_cout3), .out_valid(out_valid3), .out_ready(out_ready3),
        .out_res(out_res3), .out_carry(out_carry3), .out_zero(out_zero3),
        .out_ovf(out_ovf3), .acc(acc3)
    );

    // Issue one op on the SETTLE=1 instance; lat = cycles from accept to out_valid
    // (20 means it never came).
    task automatic run_op(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                          output int lat);
        @(negedge clk);
        in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic release_op();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || acc !== 4'h0 || out_res !== 4'h0) begin
            errors++;
            $display("FAIL reset_state: ready=%b valid=%b acc=%h res=%h, need 0 0 0 0",
                     in_ready, out_valid, acc, out_res);
        end
        checks++;
        if ({as_a, as_b, as_m, out_carry, out_zero, out_ovf} !== 12'h000) begin
            errors++;
            $display("FAIL reset_drive: A=%h B=%h M=%b c=%b z=%b o=%b, need all 0",
                     as_a, as_b, as_m, out_carry, out_zero, out_ovf);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || in_ready3 !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: got %b/%b need 1/1", in_ready, in_ready3);
        end
    endtask

    task automatic test_add();
        int lat;
        run_op(2'd0, 4'b0101, 4'b1011, lat);
        checks++;
        if (lat !== 1) begin
            errors++;
            $display("FAIL add_latency: got %0d need 1", lat);
        end
        checks++;
        if ({out_res, out_carry, out_zero, out_ovf} !== 7'b0000_1_1_0) begin
            errors++;
            $display("FAIL add_result: res=%b c=%b z=%b o=%b need 0000 1 1 0",
                     out_res, out_carry, out_zero, out_ovf);
        end
        release_op();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL add_release: valid=%b ready=%b need 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_sub();
        int lat;
        run_op(2'd1, 4'b0101, 4'b1011, lat);
        checks++;
        if (as_m !== 1'b1 || lat !== 1) begin
            errors++;
            $display("FAIL sub_drive: M=%b lat=%0d need 1 1", as_m, lat);
        end
        checks++;
        if ({out_res, out_carry, out_zero, out_ovf} !== 7'b1010_0_0_1) begin
            errors++;
            $display("FAIL sub1_result: res=%b c=%b z=%b o=%b need 1010 0 0 1",
                     out_res, out_carry, out_zero, out_ovf);
        end
        release_op();
        run_op(2'd1, 4'b0110, 4'b1111, lat);
        checks++;
        if ({out_res, out_carry, out_zero, out_ovf} !== 7'b0111_0_0_0) begin
            errors++;
            $display("FAIL sub2_result: res=%b c=%b z=%b o=%b need 0111 0 0 0",
                     out_res, out_carry, out_zero, out_ovf);
        end
        release_op();
    endtask

    task automatic test_acc_chain();
        int lat;
        run_op(2'd0, 4'b0111, 4'b0000, lat);
        checks++;
        if (acc !== 4'b0111) begin
            errors++;
            $display("FAIL acc_load: got %b need 0111", acc);
        end
        release_op();
        // in_a is junk on ACC ops and must be ignored.
        run_op(2'd2, 4'b1111, 4'b0011, lat);
        checks++;
        if ({out_res, out_carry, out_ovf, acc} !== 10'b1010_0_1_1010 || as_a !== 4'b0111) begin
            errors++;
            $display("FAIL acc_add: res=%b c=%b o=%b acc=%b A=%b need 1010 0 1 1010 0111",
                     out_res, out_carry, out_ovf, acc, as_a);
        end
        release_op();
        run_op(2'd3, 4'b0001, 4'b1010, lat);
        checks++;
        if ({out_res, out_carry, out_zero, acc} !== 10'b0000_1_1_0000) begin
            errors++;
            $display("FAIL acc_sub: res=%b c=%b z=%b acc=%b need 0000 1 1 0000",
                     out_res, out_carry, out_zero, acc);
        end
        release_op();
    endtask

    task automatic test_backpressure();
        int lat;
        run_op(2'd0, 4'b0011, 4'b0100, lat);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({out_valid, in_ready, out_res, out_carry, out_zero, out_ovf} !== 9'b1_0_0111_000
                || {as_a, as_b, as_m} !== 9'b0011_0100_0) begin
                errors++;
                $display("FAIL hold_stable[%0d]: v=%b r=%b res=%b A=%b B=%b M=%b", i,
                         out_valid, in_ready, out_res, as_a, as_b, as_m);
            end
            if (i == 2) in_valid = 1'b1;
            else in_valid = 1'b0;
            in_op = 2'd1; in_a = 4'b1111; in_b = 4'b1111;
            @(posedge clk);
            @(negedge clk);
        end
        in_valid = 1'b0;
        release_op();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL hold_release: ready=%b valid=%b need 1 0", in_ready, out_valid);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || acc !== 4'b0111 || as_a !== 4'b0011) begin
            errors++;
            $display("FAIL dropped_op: valid=%b acc=%b A=%b need 0 0111 0011",
                     out_valid, acc, as_a);
        end
    endtask

    task automatic test_settle3_and_abort();
        int lat;
        @(negedge clk);
        in_valid3 = 1'b1; in_op3 = 2'd0; in_a3 = 4'b0001; in_b3 = 4'b0010;
        @(posedge clk);
        @(negedge clk);
        in_valid3 = 1'b0;
        lat = 0;
        while (!out_valid3 && lat < 20) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat !== 3 || out_res3 !== 4'b0011 || acc3 !== 4'b0011) begin
            errors++;
            $display("FAIL settle3: lat=%0d res=%b acc=%b need 3 0011 0011", lat, out_res3, acc3);
        end
        out_ready3 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready3 = 1'b0;
        in_valid3 = 1'b1; in_op3 = 2'd2; in_b3 = 4'b0001;
        @(posedge clk);
        @(negedge clk);
        in_valid3 = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (in_ready3 !== 1'b0) begin
            errors++;
            $display("FAIL ready_in_rst: got %b need 0", in_ready3);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (out_valid3 !== 1'b0 || acc3 !== 4'h0 || in_ready3 !== 1'b1) begin
                errors++;
                $display("FAIL abort[%0d]: valid=%b acc=%b ready=%b need 0 0000 1",
                         i, out_valid3, acc3, in_ready3);
            end
        end
    endtask

    task automatic test_saturation();
        int lat;
        run_op(2'd0, 4'b1001, 4'b1110, lat);
`ifdef AS_SEQ_SAT_EN
        checks++;
        if ({out_res, out_carry, acc} !== 9'b1111_1_1111) begin
            errors++;
            $display("FAIL sat_add: res=%b c=%b acc=%b need 1111 1 1111", out_res, out_carry, acc);
        end
`else
        checks++;
        if ({out_res, out_carry, acc} !== 9'b0111_1_0111) begin
            errors++;
            $display("FAIL wrap_add: res=%b c=%b acc=%b need 0111 1 0111", out_res, out_carry, acc);
        end
`endif
        release_op();
        run_op(2'd1, 4'b0001, 4'b1101, lat);
`ifdef AS_SEQ_SAT_EN
        checks++;
        if ({out_res, out_carry, out_zero} !== 6'b0000_0_1) begin
            errors++;
            $display("FAIL sat_sub: res=%b c=%b z=%b need 0000 0 1", out_res, out_carry, out_zero);
        end
`else
        checks++;
        if ({out_res, out_carry, out_zero} !== 6'b0100_0_0) begin
            errors++;
            $display("FAIL wrap_sub: res=%b c=%b z=%b need 0100 0 0", out_res, out_carry, out_zero);
        end
`endif
        release_op();
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_acc_chain();
        test_backpressure();
        test_settle3_and_abort();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
